inst_fetch_queue: RTL and testbench

//  Fetch-side initiator for the instruction ROM bus (nrd active-low, 32-bit byte address, 32-bit big-endian word).

---
 rtl/inst_fetch_queue_pkg.sv | 12 +
 rtl/inst_fetch_queue_fifo.sv | 53 +++++
 rtl/inst_fetch_queue.sv | 72 +++++++
 tb/tb_inst_fetch_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths and queue entry type for the instruction fetch queue
package inst_fetch_queue_pkg;
  localparam int INST_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;
endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// rtl/inst_fetch_queue_fifo.sv - DEPTH-entry circular buffer of {pc, inst} with push/pop/flush
module inst_fetch_queue_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  ifq_entry_t wdata,
  output ifq_entry_t rdata,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  ifq_entry_t      mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - PC walker and ROM read initiator feeding an in-order instruction queue
// Optional zero-latency empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
  parameter logic [ADDR_W-1:0] PC_LIMIT = 32'd100
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              nrd,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [INST_W-1:0] romData,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirectPc,
  output logic              instValid,
  output logic [INST_W-1:0] instOut,
  output logic [ADDR_W-1:0] instPc,
  input  logic              instReady,
  output logic              fetchIdle
);
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  ifq_entry_t        head;
  logic              full;
  logic              empty;
  logic              fifo_pop;
  logic              fetch_en;
  logic              push;

  assign pc_inc    = pc + ADDR_W'(WORD_BYTES);
  assign fetchIdle = (pc_inc > PC_LIMIT);

  // A pop during redirect is dropped: the flush discards the head anyway
  assign fifo_pop = !empty && instReady && !redirect;
  assign fetch_en = nrst && !redirect && !fetchIdle && (!full || fifo_pop);
  assign nrd      = !fetch_en;
  assign romAddr  = nrst ? pc : '0;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)          pc <= RESET_PC;
    else if (redirect)  pc <= redirectPc & ~ADDR_W'(3);
    else if (fetch_en)  pc <= pc_inc;
  end

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = empty && fetch_en;
  assign push      = fetch_en && !(bypass && instReady);
  assign instValid = !empty || bypass;
  assign instOut   = !empty ? head.inst : (bypass ? romData : NOP);
  assign instPc    = !empty ? head.pc   : (bypass ? pc : '0);
`else
  assign push      = fetch_en;
  assign instValid = !empty;
  assign instOut   = empty ? NOP : head.inst;
  assign instPc    = empty ? '0  : head.pc;
`endif

  inst_fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (fifo_pop),
    .flush (redirect),
    .wdata ('{pc: pc, inst: romData}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue with directed fetch/redirect/reset vectors
module tb_inst_fetch_queue;
  logic        clk = 1'b0;
  logic        nrst;
  logic        nrd;
  logic [31:0] romAddr;
  wire  [31:0] romData;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        instValid;
  logic [31:0] instOut;
  logic [31:0] instPc;
  logic        instReady;
  logic        fetchIdle;

`ifdef IFQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h1122_3344;
      32'd4:   return 32'h5566_7788;
      default: return 32'hC000_0000 | a;
    endcase
  endfunction

  assign romData = nrd ? 32'hzzzz_zzzz : rom_word(romAddr);

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0), .PC_LIMIT(32'd100)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .nrd        (nrd),
    .romAddr    (romAddr),
    .romData    (romData),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .instValid  (instValid),
    .instOut    (instOut),
    .instPc     (instPc),
    .instReady  (instReady),
    .fetchIdle  (fetchIdle)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [31:0] lo, input logic [31:0] hi);
    for (logic [31:0] a = lo; a <= hi; a += 4) exp_q.push_back('{pc: a, inst: rom_word(a)});
  endtask

  task automatic run_to_idle_and_drain(input string nm);
    int n;
    for (n = 0; n < 200; n++) begin
      tick();
      if (fetchIdle) break;
    end
    check({nm, "_idle_reached"}, {31'd0, fetchIdle}, 32'd1);
    #2;
    check({nm, "_idle_nrd"}, {31'd0, nrd}, 32'd1);
    check({nm, "_idle_addr"}, romAddr, 32'd100);
    repeat (8) tick();
    check({nm, "_drained"}, exp_q.size(), 32'd0);
    check({nm, "_empty_valid"}, {31'd0, instValid}, 32'd0);
  endtask

  // Monitor: every accepted head must match the next expected entry
  always @(negedge clk) begin
    if (nrst && instValid && instReady && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h inst %h expected none", instPc, instOut);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", instPc, e.pc);
        check("sb_inst", instOut, e.inst);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; redirect = 1'b0; redirectPc = 32'd0; instReady = 1'b0;
    tick(); tick();
    check("rst_nrd", {31'd0, nrd}, 32'd1);
    check("rst_addr", romAddr, 32'd0);
    check("rst_valid", {31'd0, instValid}, 32'd0);
    check("rst_inst", instOut, 32'd0);
    check("rst_pc", instPc, 32'd0);
    check("rst_idle", {31'd0, fetchIdle}, 32'd0);

    // Fill with instReady low, then release: pc 0..96 stream in order
    nrst = 1'b1;
    push_range(32'd0, 32'd96);
    #2;
    check("t2_first_nrd", {31'd0, nrd}, 32'd0);
    check("t2_first_addr", romAddr, 32'd0);
    tick(); tick(); tick(); tick();
    #2;
    check("t2_full_nrd", {31'd0, nrd}, 32'd1);
    check("t2_full_addr", romAddr, 32'd16);
    check("t2_head_pc", instPc, 32'd0);
    check("t2_head_inst", instOut, 32'h1122_3344);
    tick(); tick();
    check("t2_hold_nrd", {31'd0, nrd}, 32'd1);
    check("t2_hold_addr", romAddr, 32'd16);
    tick();
    instReady = 1'b1;
    #2;
    check("t2_resume_nrd", {31'd0, nrd}, 32'd0);
    check("t2_resume_addr", romAddr, 32'd16);
    run_to_idle_and_drain("t2");

    // Redirect out of idle, then build a 2-deep queue
    redirect = 1'b1; redirectPc = 32'd8; instReady = 1'b0;
    #2;
    check("t4_redir_nrd", {31'd0, nrd}, 32'd1);
    tick();
    redirect = 1'b0;
    #2;
    check("t4_idle_clr", {31'd0, fetchIdle}, 32'd0);
    check("t4_fetch_nrd", {31'd0, nrd}, 32'd0);
    check("t4_fetch_addr", romAddr, 32'd8);
    check("t4_valid", {31'd0, instValid}, {31'd0, BYP});
    tick(); tick();

    // Redirect with 2 entries queued to an unaligned target
    redirect = 1'b1; redirectPc = 32'h22;
    #2;
    check("t3_pre_pc", instPc, 32'd8);
    check("t3_pre_nrd", {31'd0, nrd}, 32'd1);
    tick();
    redirect = 1'b0;
    push_range(32'h20, 32'd96);
    #2;
    check("t3_valid", {31'd0, instValid}, {31'd0, BYP});
    check("t3_addr", romAddr, 32'h20);
    check("t3_nrd", {31'd0, nrd}, 32'd0);
    tick();
    #2;
    check("t3_head_pc", instPc, 32'h20);
    instReady = 1'b1;
    run_to_idle_and_drain("t3");

    // Asynchronous reset with 3 entries queued
    redirect = 1'b1; redirectPc = 32'd0; instReady = 1'b0;
    tick();
    redirect = 1'b0;
    tick(); tick(); tick();
    #2;
    check("t5_pre_valid", {31'd0, instValid}, 32'd1);
    nrst = 1'b0;
    #1;
    check("t5_async_valid", {31'd0, instValid}, 32'd0);
    check("t5_async_nrd", {31'd0, nrd}, 32'd1);
    check("t5_async_inst", instOut, 32'd0);
    tick();
    nrst = 1'b1; instReady = 1'b1;
    push_range(32'd0, 32'd96);
    #2;
    check("t6_nrd", {31'd0, nrd}, 32'd0);
    check("t6_addr", romAddr, 32'd0);
    check("t6_same_cycle_valid", {31'd0, instValid}, {31'd0, BYP});
    tick();
    #2;
    check("t6_next_valid", {31'd0, instValid}, 32'd1);
    check("t6_next_pc", instPc, BYP ? 32'd4 : 32'd0);
    run_to_idle_and_drain("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
